// File: rtl/calc_sequencer.sv
// -----------------------------------------------------------------------------
// calc_sequencer
//
// Central control FSM of the calculator datapath. It turns decoded keypad
// events into decimal operands (built in an internal accumulator) and drives
// the load strobes of the A, B, opcode and result holding registers. It also
// starts the ALU, waits for the done/error handshake, and supports chaining
// a new operation onto a shown result.
//
// Handshake: key_valid is a one-cycle strobe that qualifies key_code; there
// is no back-pressure, so a key that is not meaningful in the current state
// is simply dropped. alu_done is a one-cycle pulse qualified by alu_err; it
// is only consumed in S_WAIT.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   key_valid  in   key strobe
//   key_code   in   0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 =, 15 clear
//   alu_done   in   ALU result valid pulse
//   alu_err    in   qualifies alu_done (error result)
//   d_out      out  operand data to A/B registers
//   a_src_res  out  A register source select (1: result reg, 0: d_out)
//   load_a     out  load strobe, A register
//   load_b     out  load strobe, B register
//   load_op    out  load strobe, opcode register
//   op_code    out  00 add, 01 sub, 10 mul, 11 div
//   load_res   out  load strobe, result register
//   reg_clear  out  synchronous clear to all datapath registers
//   alu_start  out  ALU start pulse
//   busy       out  high in S_EXEC / S_WAIT
//   error      out  high in S_ERR
//   state      out  current state encoding (debug)
//
// Every output is a flop; a key accepted at edge k shows its strobes during
// cycle k+1, and each strobe is exactly one cycle wide.
// -----------------------------------------------------------------------------
module calc_sequencer #(
  parameter int bits        = 8,
  parameter int ALU_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            key_valid,
  input  logic [3:0]      key_code,
  input  logic            alu_done,
  input  logic            alu_err,
  output logic [bits-1:0] d_out,
  output logic            a_src_res,
  output logic            load_a,
  output logic            load_b,
  output logic            load_op,
  output logic [1:0]      op_code,
  output logic            load_res,
  output logic            reg_clear,
  output logic            alu_start,
  output logic            busy,
  output logic            error,
  output logic [2:0]      state
);

  // Accumulator arithmetic is done 4 bits wider so acc*10+9 never wraps.
  localparam int AW = bits + 4;
  localparam int TW = $clog2(ALU_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_A    = 3'b000,
    S_B    = 3'b001,
    S_EXEC = 3'b010,
    S_WAIT = 3'b011,
    S_SHOW = 3'b100,
    S_ERR  = 3'b101
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [bits-1:0] r_acc, w_acc_nxt;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic [bits-1:0] r_d_out, w_d_out_nxt;
  logic            r_a_src, w_a_src_nxt;
  logic [1:0]      r_op, w_op_nxt;
  logic            r_load_a, w_load_a_nxt;
  logic            r_load_b, w_load_b_nxt;
  logic            r_load_op, w_load_op_nxt;
  logic            r_load_res, w_load_res_nxt;
  logic            r_reg_clear, w_reg_clear_nxt;
  logic            r_alu_start, w_alu_start_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_error, w_error_nxt;

  // Key decode
  logic            w_is_digit, w_is_op, w_is_eq, w_is_clr;
  logic [1:0]      w_key_op;
  logic [AW-1:0]   w_acc_mul;
  logic            w_digit_ok;

  assign w_is_digit = key_valid && (key_code <= 4'd9);
  assign w_is_op    = key_valid && (key_code >= 4'd10) && (key_code <= 4'd13);
  assign w_is_eq    = key_valid && (key_code == 4'd14);
  assign w_is_clr   = key_valid && (key_code == 4'd15);
  // Op keys 10..13 map onto opcodes 0..3.
  assign w_key_op   = 2'(key_code - 4'd10);

  assign w_acc_mul  = ({4'b0000, r_acc} * AW'(10)) + {{bits{1'b0}}, key_code};
  // A digit that would push the operand past 2^bits-1 is dropped.
  assign w_digit_ok = (w_acc_mul[AW-1:bits] == '0);

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_timer_nxt     = r_timer;
    w_d_out_nxt     = r_d_out;
    w_a_src_nxt     = r_a_src;
    w_op_nxt        = r_op;
    w_load_a_nxt    = 1'b0;
    w_load_b_nxt    = 1'b0;
    w_load_op_nxt   = 1'b0;
    w_load_res_nxt  = 1'b0;
    w_reg_clear_nxt = 1'b0;
    w_alu_start_nxt = 1'b0;

    if (w_is_clr) begin
      // Clear wins in every state, including over a same-edge alu_done,
      // and aborts any operation in flight.
      w_reg_clear_nxt = 1'b1;
      w_acc_nxt       = '0;
      w_a_src_nxt     = 1'b0;
      w_state_nxt     = S_A;
    end else begin
      case (r_state)
        S_A: begin
          if (w_is_digit) begin
            if (w_digit_ok) w_acc_nxt = w_acc_mul[bits-1:0];
          end else if (w_is_op) begin
            w_d_out_nxt   = r_acc;
            w_a_src_nxt   = 1'b0;
            w_load_a_nxt  = 1'b1;
            w_op_nxt      = w_key_op;
            w_load_op_nxt = 1'b1;
            w_acc_nxt     = '0;
            w_state_nxt   = S_B;
          end
        end
        S_B: begin
          if (w_is_digit) begin
            if (w_digit_ok) w_acc_nxt = w_acc_mul[bits-1:0];
          end else if (w_is_op) begin
            // Operator correction: only the opcode changes.
            w_op_nxt      = w_key_op;
            w_load_op_nxt = 1'b1;
          end else if (w_is_eq) begin
            w_d_out_nxt  = r_acc;
            w_load_b_nxt = 1'b1;
            w_acc_nxt    = '0;
            w_state_nxt  = S_EXEC;
          end
        end
        S_EXEC: begin
          w_alu_start_nxt = 1'b1;
          w_timer_nxt     = '0;
          w_state_nxt     = S_WAIT;
        end
        S_WAIT: begin
          if (alu_done) begin
            if (alu_err) begin
              w_state_nxt = S_ERR;
            end else begin
              w_load_res_nxt = 1'b1;
              w_state_nxt    = S_SHOW;
            end
          end else if (r_timer == TW'(ALU_TIMEOUT - 1)) begin
            w_state_nxt = S_ERR;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
        S_SHOW: begin
          if (w_is_digit) begin
            // Starts a fresh operand; A is loaded on the following op key.
            w_acc_nxt   = bits'(key_code);
            w_state_nxt = S_A;
          end else if (w_is_op) begin
            // Chaining: A takes the previous result directly.
            w_a_src_nxt   = 1'b1;
            w_load_a_nxt  = 1'b1;
            w_op_nxt      = w_key_op;
            w_load_op_nxt = 1'b1;
            w_acc_nxt     = '0;
            w_state_nxt   = S_B;
          end
        end
        S_ERR: begin
          // Only clear (handled above) leaves this state.
        end
        default: begin
          w_state_nxt = S_A;
        end
      endcase
    end

    w_busy_nxt  = (w_state_nxt == S_EXEC) || (w_state_nxt == S_WAIT);
    w_error_nxt = (w_state_nxt == S_ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_A;
      r_acc       <= '0;
      r_timer     <= '0;
      r_d_out     <= '0;
      r_a_src     <= 1'b0;
      r_op        <= 2'b00;
      r_load_a    <= 1'b0;
      r_load_b    <= 1'b0;
      r_load_op   <= 1'b0;
      r_load_res  <= 1'b0;
      r_reg_clear <= 1'b0;
      r_alu_start <= 1'b0;
      r_busy      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_timer     <= w_timer_nxt;
      r_d_out     <= w_d_out_nxt;
      r_a_src     <= w_a_src_nxt;
      r_op        <= w_op_nxt;
      r_load_a    <= w_load_a_nxt;
      r_load_b    <= w_load_b_nxt;
      r_load_op   <= w_load_op_nxt;
      r_load_res  <= w_load_res_nxt;
      r_reg_clear <= w_reg_clear_nxt;
      r_alu_start <= w_alu_start_nxt;
      r_busy      <= w_busy_nxt;
      r_error     <= w_error_nxt;
    end
  end

  assign d_out     = r_d_out;
  assign a_src_res = r_a_src;
  assign load_a    = r_load_a;
  assign load_b    = r_load_b;
  assign load_op   = r_load_op;
  assign op_code   = r_op;
  assign load_res  = r_load_res;
  assign reg_clear = r_reg_clear;
  assign alu_start = r_alu_start;
  assign busy      = r_busy;
  assign error     = r_error;
  assign state     = r_state;

endmodule

// File: tb/tb_calc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_sequencer
//
// Table-driven bench for calc_sequencer: each record holds one cycle of
// inputs and the outputs expected right after the clock edge that samples
// them. Hand-written sequences cover the ALU timeout, clear racing alu_done,
// and asynchronous reset in the middle of an operation.
// -----------------------------------------------------------------------------
module tb_calc_sequencer;

  localparam int TO = 15;

  localparam logic [3:0] K_ADD = 4'd10;
  localparam logic [3:0] K_SUB = 4'd11;
  localparam logic [3:0] K_DIV = 4'd13;
  localparam logic [3:0] K_EQ  = 4'd14;
  localparam logic [3:0] K_CLR = 4'd15;

  localparam logic [2:0] SA = 3'd0, SB = 3'd1, SX = 3'd2, SW = 3'd3,
                         SS = 3'd4, SE = 3'd5;

  // Flag vector: {a_src_res, load_a, load_b, load_op, load_res,
  //               reg_clear, alu_start, busy, error}
  localparam logic [8:0] F_ASRC = 9'h100;
  localparam logic [8:0] F_LA   = 9'h080;
  localparam logic [8:0] F_LB   = 9'h040;
  localparam logic [8:0] F_LO   = 9'h020;
  localparam logic [8:0] F_LR   = 9'h010;
  localparam logic [8:0] F_RC   = 9'h008;
  localparam logic [8:0] F_AS   = 9'h004;
  localparam logic [8:0] F_BUSY = 9'h002;
  localparam logic [8:0] F_ERR  = 9'h001;

  // clock / reset
  logic       clk = 1'b0;
  logic       reset;
  always #5 clk = ~clk;

  logic       key_valid, alu_done, alu_err;
  logic [3:0] key_code;
  logic [7:0] d_out;
  logic       a_src_res, load_a, load_b, load_op, load_res;
  logic       reg_clear, alu_start, busy, error;
  logic [1:0] op_code;
  logic [2:0] state;
  logic [8:0] w_flags;

  assign w_flags = {a_src_res, load_a, load_b, load_op, load_res,
                    reg_clear, alu_start, busy, error};

  calc_sequencer #(.bits(8), .ALU_TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .alu_done  (alu_done),
    .alu_err   (alu_err),
    .d_out     (d_out),
    .a_src_res (a_src_res),
    .load_a    (load_a),
    .load_b    (load_b),
    .load_op   (load_op),
    .op_code   (op_code),
    .load_res  (load_res),
    .reg_clear (reg_clear),
    .alu_start (alu_start),
    .busy      (busy),
    .error     (error),
    .state     (state)
  );

  typedef struct {
    logic       kv;
    logic [3:0] kc;
    logic       done;
    logic       err;
    logic [2:0] st;
    logic [7:0] dout;
    logic [1:0] opc;
    logic [8:0] fl;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add_vec(input logic kv, input logic [3:0] kc,
                         input logic d, input logic e,
                         input logic [2:0] st, input logic [7:0] dout,
                         input logic [1:0] opc, input logic [8:0] fl);
    vec_t v;
    v.kv = kv; v.kc = kc; v.done = d; v.err = e;
    v.st = st; v.dout = dout; v.opc = opc; v.fl = fl;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1ns after
  // the rising edge that consumed them
  task automatic step(input logic kv, input logic [3:0] kc,
                      input logic d, input logic e);
    @(negedge clk);
    key_valid = kv;
    key_code  = kc;
    alu_done  = d;
    alu_err   = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    alu_done  = 1'b0;
    alu_err   = 1'b0;

    // 1: 12 + 3, ALU done two cycles after the idle following alu_start
    add_vec(1, 4'd1,  0, 0, SA, 8'd0,  2'd0, 9'h0);
    add_vec(1, 4'd2,  0, 0, SA, 8'd0,  2'd0, 9'h0);
    add_vec(1, K_ADD, 0, 0, SB, 8'd12, 2'd0, F_LA | F_LO);
    add_vec(1, 4'd3,  0, 0, SB, 8'd12, 2'd0, 9'h0);
    add_vec(1, K_EQ,  0, 0, SX, 8'd3,  2'd0, F_LB | F_BUSY);
    add_vec(0, 4'd0,  0, 0, SW, 8'd3,  2'd0, F_AS | F_BUSY);
    add_vec(0, 4'd0,  0, 0, SW, 8'd3,  2'd0, F_BUSY);
    add_vec(0, 4'd0,  0, 0, SW, 8'd3,  2'd0, F_BUSY);
    add_vec(0, 4'd0,  1, 0, SS, 8'd3,  2'd0, F_LR);
    add_vec(0, 4'd0,  0, 0, SS, 8'd3,  2'd0, 9'h0);
    // 5: chain sub 4; digit arriving with alu_done is discarded
    add_vec(1, K_SUB, 0, 0, SB, 8'd3,  2'd1, F_ASRC | F_LA | F_LO);
    add_vec(1, 4'd4,  0, 0, SB, 8'd3,  2'd1, F_ASRC);
    add_vec(1, K_EQ,  0, 0, SX, 8'd4,  2'd1, F_ASRC | F_LB | F_BUSY);
    add_vec(0, 4'd0,  0, 0, SW, 8'd4,  2'd1, F_ASRC | F_AS | F_BUSY);
    add_vec(1, 4'd5,  1, 0, SS, 8'd4,  2'd1, F_ASRC | F_LR);
    add_vec(1, 4'd7,  0, 0, SA, 8'd4,  2'd1, F_ASRC);
    // 3: 7 / 0 -> ALU error; keys ignored in S_ERR; clear recovers
    add_vec(1, K_DIV, 0, 0, SB, 8'd7,  2'd3, F_LA | F_LO);
    add_vec(1, 4'd0,  0, 0, SB, 8'd7,  2'd3, 9'h0);
    add_vec(1, K_EQ,  0, 0, SX, 8'd0,  2'd3, F_LB | F_BUSY);
    add_vec(0, 4'd0,  0, 0, SW, 8'd0,  2'd3, F_AS | F_BUSY);
    add_vec(0, 4'd0,  1, 1, SE, 8'd0,  2'd3, F_ERR);
    add_vec(1, K_EQ,  0, 0, SE, 8'd0,  2'd3, F_ERR);
    add_vec(1, 4'd3,  0, 0, SE, 8'd0,  2'd3, F_ERR);
    add_vec(0, 4'd0,  1, 0, SE, 8'd0,  2'd3, F_ERR);
    add_vec(1, K_CLR, 0, 0, SA, 8'd0,  2'd3, F_RC);
    add_vec(0, 4'd0,  0, 0, SA, 8'd0,  2'd3, 9'h0);
    // 2: 2,5,5 -> 255; 6 and 9 rejected; add loads 255
    add_vec(1, 4'd2,  0, 0, SA, 8'd0,  2'd3, 9'h0);
    add_vec(1, 4'd5,  0, 0, SA, 8'd0,  2'd3, 9'h0);
    add_vec(1, 4'd5,  0, 0, SA, 8'd0,  2'd3, 9'h0);
    add_vec(1, 4'd6,  0, 0, SA, 8'd0,  2'd3, 9'h0);
    add_vec(1, 4'd9,  0, 0, SA, 8'd0,  2'd3, 9'h0);
    add_vec(1, K_ADD, 0, 0, SB, 8'd255, 2'd0, F_LA | F_LO);
    add_vec(0, 4'd0,  0, 0, SB, 8'd255, 2'd0, 9'h0);
    // 6: clear during S_WAIT, later alu_done ignored
    add_vec(1, 4'd1,  0, 0, SB, 8'd255, 2'd0, 9'h0);
    add_vec(1, K_EQ,  0, 0, SX, 8'd1,  2'd0, F_LB | F_BUSY);
    add_vec(0, 4'd0,  0, 0, SW, 8'd1,  2'd0, F_AS | F_BUSY);
    add_vec(1, K_CLR, 0, 0, SA, 8'd1,  2'd0, F_RC);
    add_vec(0, 4'd0,  1, 0, SA, 8'd1,  2'd0, 9'h0);
    add_vec(0, 4'd0,  0, 0, SA, 8'd1,  2'd0, 9'h0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_all", 0, {21'd0, d_out, w_flags, op_code, state}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].kv, vecs[i].kc, vecs[i].done, vecs[i].err);
      chk("state", i, {29'd0, state},   {29'd0, vecs[i].st});
      chk("d_out", i, {24'd0, d_out},   {24'd0, vecs[i].dout});
      chk("opc",   i, {30'd0, op_code}, {30'd0, vecs[i].opc});
      chk("flags", i, {23'd0, w_flags}, {23'd0, vecs[i].fl});
    end

    // 4: timeout, counted from the edge that enters S_WAIT
    begin
      int n;
      step(1, 4'd5, 0, 0);
      step(1, K_ADD, 0, 0);
      step(1, 4'd6, 0, 0);
      step(1, K_EQ, 0, 0);
      step(0, 4'd0, 0, 0);
      chk("to_wait_entry", 0, {29'd0, state}, {29'd0, SW});
      n = 0;
      do begin
        step(0, 4'd0, 0, 0);
        n++;
      end while (state !== SE && n < 40);
      chk("to_cycles", 0, n, TO);
      chk("to_error", 0, {31'd0, error}, 32'd1);
      step(1, K_CLR, 0, 0);
      chk("to_clear", 0, {23'd0, w_flags}, {23'd0, F_RC});
    end

    // clear and alu_done on the same edge: clear wins, no load_res
    step(1, 4'd2, 0, 0);
    step(1, K_ADD, 0, 0);
    step(1, 4'd3, 0, 0);
    step(1, K_EQ, 0, 0);
    step(0, 4'd0, 0, 0);
    step(1, K_CLR, 1, 0);
    chk("race_state", 0, {29'd0, state}, {29'd0, SA});
    chk("race_flags", 0, {23'd0, w_flags}, {23'd0, F_RC});
    step(0, 4'd0, 0, 0);
    chk("race_after", 0, {23'd0, w_flags}, 32'd0);

    // async reset while a load_op strobe is in flight in S_B
    step(1, 4'd3, 0, 0);
    step(1, K_ADD, 0, 0);
    step(1, K_SUB, 0, 0);
    chk("pre_rst_lo", 0, {23'd0, w_flags}, {23'd0, F_LO});
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst", 0, {21'd0, d_out, w_flags, op_code, state}, 32'd0);
    @(negedge clk);
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    step(0, 4'd0, 0, 0);
    chk("post_rst", 0, {21'd0, d_out, w_flags, op_code, state}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Central control FSM for the calculator datapath. Takes decoded keypad events, builds decimal operands in an internal accumulator and drives the load strobes of the operand-A, operand-B, opcode and result holding registers. Those registers are the loadable, synchronously cleared registers used throughout the datapath. The block also starts the ALU, waits for its done/error handshake, and supports chained operations.

Parameters:
bits, 8, operand/result width; accumulator and d_out width
ALU_TIMEOUT, 15, max cycles in S_WAIT without alu_done before entering S_ERR (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  4  0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 equals, 15 clear
alu_done  in  1  ALU result valid, one-cycle pulse
alu_err  in  1  qualifies alu_done (e.g. divide by zero)
d_out  out  bits  data to A/B registers (registered)
a_src_res  out  1  1: A register loads from result register, 0: from d_out
load_a  out  1  one-cycle load strobe, A register
load_b  out  1  one-cycle load strobe, B register
load_op  out  1  one-cycle load strobe, opcode register
op_code  out  2  00 add, 01 sub, 10 mul, 11 div (registered)
load_res  out  1  one-cycle load strobe, result register
reg_clear  out  1  one-cycle synchronous clear to all datapath registers
alu_start  out  1  one-cycle ALU start pulse
busy  out  1  high in S_EXEC/S_WAIT
error  out  1  high in S_ERR
state  out  3  current state encoding (debug)

Behaviour:
- Reset (reset=0, async): state=S_A (000), acc=0, timer=0; all outputs 0.
- States: S_A 000, S_B 001, S_EXEC 010, S_WAIT 011, S_SHOW 100, S_ERR 101.
- All outputs are registered. A key accepted at edge k produces its strobes during cycle k+1. Strobes are exactly one cycle wide.
- Digit (S_A/S_B):
  - acc <= acc*10 + digit, computed at bits+4 width.
  - If the result exceeds 2^bits-1, the digit is ignored and acc is unchanged.
- Op key in S_A: d_out<=acc, a_src_res<=0, load_a, op_code latched, load_op, acc<=0, go to S_B.
- Op key in S_B: op_code replaced, load_op; acc kept; stay in S_B.
- Equals in S_B: d_out<=acc, load_b, acc<=0, go to S_EXEC.
- Equals in S_A, S_SHOW or S_ERR: ignored.
- S_EXEC: alu_start for one cycle, timer<=0, go to S_WAIT unconditionally.
- S_WAIT:
  - alu_done & !alu_err: load_res, go to S_SHOW.
  - alu_done & alu_err: go to S_ERR.
  - timer==ALU_TIMEOUT-1 with no alu_done: go to S_ERR.
  - Otherwise timer increments.
  - Non-clear keys are ignored in S_EXEC/S_WAIT.
- S_SHOW:
  - Digit: acc<=digit, go to S_A. A is not loaded until the next op key.
  - Op key: a_src_res<=1, load_a, op_code latched, load_op, acc<=0, go to S_B (chaining).
- S_ERR: error=1; only clear is accepted.
- Clear (key 15) in any state: reg_clear pulse, acc<=0, a_src_res<=0, go to S_A. No other strobe is issued that cycle.
  - Clear during S_WAIT aborts the operation. A later alu_done is ignored and does not produce load_res.
- alu_done outside S_WAIT: ignored.
- Async reset mid-operation: returns immediately to reset values. Strobes in flight are dropped.
- Key events arriving at the same edge as alu_done in S_WAIT: clear has priority; anything else is discarded and alu_done is processed.

Test Plan:
1. Reset then keys 1,2,add,3,equals; ALU gives done 2 cycles after alu_start -> load_a with d_out=12, load_op op_code=00, load_b d_out=3, alu_start once, load_res 1 cycle after done, state=S_SHOW.
2. bits=8, keys 2,5,5,6 -> 6 rejected, acc=255; then 9 also rejected; op key -> d_out=255.
3. A=7, div, B=0, equals; ALU returns done+err -> error=1, state=S_ERR; equals/digits ignored; clear -> reg_clear pulse, error=0, S_A.
4. Equals, then no alu_done for ALU_TIMEOUT cycles -> S_ERR exactly ALU_TIMEOUT cycles after entering S_WAIT.
5. After S_SHOW, press sub then 4, equals -> load_a with a_src_res=1, op_code=01, load_b d_out=4, new alu_start.
6. Clear during S_WAIT, then alu_done pulse -> no load_res, state=S_A. Assert reset low mid-S_B -> all outputs 0 asynchronously, state=S_A.
